// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// Program counter register at the head of the fetch path of the single-cycle
// RISC-V core. Each rising clock edge either advances the PC by STEP bytes or
// loads an externally supplied target (branch, jump, trap vector). Loaded
// targets are forced to word alignment, and a registered flag records whether
// the most recent load carried a non-word-aligned address.
//
// Parameters:
//   WIDTH         address width in bits (must be at least 3)
//   RESET_VECTOR  value driven onto pc while reset is asserted
//   STEP          byte increment applied on a sequential advance
//
// Ports:
//   clk         in   single system clock, rising-edge active
//   rst         in   asynchronous, active-low reset (0 = reset asserted)
//   inc         in   1 = advance sequentially, 0 = load extAddress
//   extAddress  in   external target address, used when inc = 0
//   pc          out  current program counter (registered)
//   pc_plus4    out  pc + STEP, modulo 2^WIDTH (combinational)
//   pc_next     out  value pc takes at the next rising edge (combinational)
//   misaligned  out  registered; set when the last load had extAddress[1:0] != 0
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [WIDTH-1:0] extAddress,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_next,
  output logic             misaligned
);

  // Sequential advance: unsigned add that wraps silently at 2^WIDTH.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] addr);
    return addr + WIDTH'(STEP);
  endfunction

  // Loaded targets are always word aligned; the low two bits are dropped.
  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Next-address select (combinational, visible to the rest of the core).
  always_comb begin
    pc_plus4 = advance(pc);
    pc_next  = inc ? pc_plus4 : word_align(extAddress);
  end

  // PC register: there is no hold state, every edge out of reset updates pc.
  // Holding is done by loading the current pc as extAddress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      pc         <= pc_next;
      misaligned <= !inc && is_misaligned(extAddress);
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//
// Directed testbench for program_counter (WIDTH=32, RESET_VECTOR=0, STEP=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// well away from the active edge.
// -----------------------------------------------------------------------------
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        inc;
  logic [31:0] extAddress;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  program_counter #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0000_0000),
    .STEP        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .extAddress(extAddress),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .pc_next   (pc_next),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Async assertion between edges (t=2, next edge at t=5).
    #2 rst = 1'b0;
    inc = 1'b0;
    extAddress = 32'h0000_1237;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL reset_async_pc: got %h expected %h", pc, 32'h0);
    end
    checks++;
    if (misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_async_mis: got %b expected %b", misaligned, 1'b0);
    end
    // Edges with reset held low and varied inputs must not move pc.
    for (int i = 0; i < 3; i++) begin
      inc = i[0];
      extAddress = 32'h0000_5003 + 32'(i) * 32'h100;
      tick();
      checks++;
      if (pc !== 32'h0 || misaligned !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got pc=%h mis=%b expected pc=%h mis=0", i, pc, misaligned, 32'h0);
      end
    end
    // Release: the first edge applies the normal rule to RESET_VECTOR.
    rst = 1'b1;
    inc = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0000_0004) begin
      errors++; $display("FAIL reset_release_pc: got %h expected %h", pc, 32'h4);
    end
  endtask

  task automatic test_load();
    inc = 1'b0;
    extAddress = 32'h0000_1000;
    #1;
    checks++;
    if (pc_next !== 32'h0000_1000) begin
      errors++; $display("FAIL load_pc_next: got %h expected %h", pc_next, 32'h1000);
    end
    tick();
    checks++;
    if (pc !== 32'h0000_1000) begin
      errors++; $display("FAIL load_pc: got %h expected %h", pc, 32'h1000);
    end
    checks++;
    if (misaligned !== 1'b0) begin
      errors++; $display("FAIL load_mis: got %b expected %b", misaligned, 1'b0);
    end
    checks++;
    if (pc_plus4 !== 32'h0000_1004) begin
      errors++; $display("FAIL load_pc_plus4: got %h expected %h", pc_plus4, 32'h1004);
    end
  endtask

  task automatic test_increment();
    inc = 1'b1;
    #1;
    checks++;
    if (pc_next !== 32'h0000_1004) begin
      errors++; $display("FAIL inc_pc_next: got %h expected %h", pc_next, 32'h1004);
    end
    tick();
    checks++;
    if (pc !== 32'h0000_1004) begin
      errors++; $display("FAIL inc_pc: got %h expected %h", pc, 32'h1004);
    end
    checks++;
    if (pc_plus4 !== 32'h0000_1008) begin
      errors++; $display("FAIL inc_pc_plus4: got %h expected %h", pc_plus4, 32'h1008);
    end
    inc = 1'b0;
    extAddress = 32'h0000_1000;
    tick();
    checks++;
    if (pc !== 32'h0000_1000) begin
      errors++; $display("FAIL inc_reload_pc: got %h expected %h", pc, 32'h1000);
    end
    checks++;
    if (pc_plus4 !== 32'h0000_1004) begin
      errors++; $display("FAIL inc_reload_pc_plus4: got %h expected %h", pc_plus4, 32'h1004);
    end
  endtask

  task automatic test_hold();
    inc = 1'b0;
    extAddress = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pc !== 32'h0000_1000) begin
        errors++; $display("FAIL hold[%0d]: got %h expected %h", i, pc, 32'h1000);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    inc = 1'b0;
    extAddress = 32'h0000_2000;
    tick();
    checks++;
    if (pc !== 32'h0000_2000) begin
      errors++; $display("FAIL mid_load_pc: got %h expected %h", pc, 32'h2000);
    end
    // Pulse reset for 10 time units, spanning one rising edge.
    rst = 1'b0;
    #2;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset_async: got %h expected %h", pc, 32'h0);
    end
    #8;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset_over_edge: got %h expected %h", pc, 32'h0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0000_2000) begin
      errors++; $display("FAIL mid_after_release: got %h expected %h", pc, 32'h2000);
    end
  endtask

  task automatic test_wrap_alignment();
    inc = 1'b0;
    extAddress = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_load: got %h expected %h", pc, 32'hFFFFFFFC);
    end
    inc = 1'b1;
    #1;
    checks++;
    if (pc_plus4 !== 32'h0 || pc_next !== 32'h0) begin
      errors++; $display("FAIL wrap_comb: got plus4=%h next=%h expected %h", pc_plus4, pc_next, 32'h0);
    end
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0);
    end
    inc = 1'b0;
    extAddress = 32'h0000_1003;
    #1;
    checks++;
    if (pc_next !== 32'h0000_1000) begin
      errors++; $display("FAIL align_pc_next: got %h expected %h", pc_next, 32'h1000);
    end
    tick();
    checks++;
    if (pc !== 32'h0000_1000 || misaligned !== 1'b1) begin
      errors++; $display("FAIL align_load: got pc=%h mis=%b expected pc=%h mis=1", pc, misaligned, 32'h1000);
    end
    inc = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0000_1004 || misaligned !== 1'b0) begin
      errors++; $display("FAIL align_inc_clear: got pc=%h mis=%b expected pc=%h mis=0", pc, misaligned, 32'h1004);
    end
    inc = 1'b0;
    extAddress = 32'h0000_3002;
    tick();
    checks++;
    if (pc !== 32'h0000_3000 || misaligned !== 1'b1) begin
      errors++; $display("FAIL align_load2: got pc=%h mis=%b expected pc=%h mis=1", pc, misaligned, 32'h3000);
    end
    extAddress = 32'h0000_2000;
    tick();
    checks++;
    if (pc !== 32'h0000_2000 || misaligned !== 1'b0) begin
      errors++; $display("FAIL align_aligned_clear: got pc=%h mis=%b expected pc=%h mis=0", pc, misaligned, 32'h2000);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    inc = 1'b0;
    extAddress = 32'h0;
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL b2b_start: got %h expected %h", pc, 32'h0);
    end
    inc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp_pc = 32'(i) * 32'd4;
      tick();
      checks++;
      if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL b2b_step[%0d]: got pc=%h plus4=%h expected pc=%h plus4=%h",
                 i, pc, pc_plus4, exp_pc, exp_pc + 32'd4);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    inc = 1'b0;
    extAddress = 32'h0;
    test_reset();
    test_load();
    test_increment();
    test_hold();
    test_reset_mid_run();
    test_wrap_alignment();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Program counter register for the single-cycle RISC-V core. Holds the address of the instruction being fetched. Each clock it either advances to the next sequential instruction or loads an externally supplied target address (branch, jump, trap vector). It sits at the head of the fetch path, feeding the instruction memory address port and the PC+4 adder consumers (JAL/JALR link value).

## Interface
Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h00000000, value loaded into `pc` during reset.
- STEP, 4, byte increment applied on sequential advance.

Ports (clock and reset first):
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- inc  input  1  select: 1 = advance sequentially, 0 = load `extAddress`.
- extAddress  input  WIDTH  external target address, used when `inc`=0.
- pc  output  WIDTH  current program counter (registered).
- pc_plus4  output  WIDTH  combinational `pc + STEP`, modulo 2^WIDTH.
- pc_next  output  WIDTH  combinational value `pc` will take at the next edge.
- misaligned  output  1  registered flag, set when the last load carried a non-word-aligned address.

## Operation
- Next-state select:
  - `inc`=1: `pc_next = pc + STEP`.
  - `inc`=0: `pc_next = {extAddress[WIDTH-1:2], 2'b00}`. The low two bits are forced to zero.
- `pc <= pc_next` on every rising `clk` edge while `rst`=1. There is no hold state. Holding requires driving `inc`=0 with `extAddress`=`pc`.
- Arithmetic is unsigned, WIDTH bits, with wrap-around. For WIDTH=32, 32'hFFFFFFFC + 4 gives 32'h00000000. No carry or overflow output.
- `misaligned`:
  - On an edge with `inc`=0, it takes the value `(extAddress[1:0] != 0)`.
  - On an edge with `inc`=1, it clears to 0.
- `pc_plus4` and `pc_next` are purely combinational from `pc`, `inc` and `extAddress`.

## Timing
- Reset:
  - `rst` falling drives `pc`=RESET_VECTOR and `misaligned`=0 immediately, with no clock needed.
  - Both hold while `rst`=0, regardless of `clk`, `inc` and `extAddress`.
- Reset release: the first rising edge with `rst`=1 applies the normal next-state rule to RESET_VECTOR.
- Reset mid-operation overrides any pending load or increment in the same cycle.
- Latency: one cycle from `inc`/`extAddress` to `pc`. Inputs are sampled at the edge. `pc_next` reflects input changes within the same cycle.
- Simultaneous `rst`=0 and a clock edge: reset wins.
- No handshake. `inc` and `extAddress` must be stable around each rising edge.

## Test plan
- Reset: `rst`=0 with arbitrary inputs, then toggle `clk` -> `pc`=0x00000000 and `misaligned`=0 throughout. Also assert `rst`=0 between edges -> `pc` clears with no edge.
- Load: `rst`=1, `inc`=0, `extAddress`=0x1000, one edge -> `pc`=0x1000. Before the edge, `pc_next`=0x1000.
- Increment: from `pc`=0x1000, `inc`=1 for one edge -> `pc`=0x1004. Then `inc`=0, `extAddress`=0x1000 -> `pc`=0x1000. Check `pc_plus4`=`pc`+4 every cycle.
- Load then reset mid-run: `inc`=0, `extAddress`=0x2000, one edge -> `pc`=0x2000. Then pulse `rst`=0 for 10 time units -> `pc`=0x0. After release with `extAddress`=0x2000 and `inc`=0 -> `pc`=0x2000 on the next edge.
- Wrap and alignment:
  - Load 0xFFFFFFFC, then `inc`=1 -> `pc`=0x00000000.
  - Load `extAddress`=0x00001003 -> `pc`=0x00001000 and `misaligned`=1. The next edge with `inc`=1 -> `misaligned`=0.
- Sustained increment: 8 consecutive edges with `inc`=1 from 0x0 -> `pc` steps 0x4, 0x8, …, 0x20.
